// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard receiver and decoder producing one-cycle editor events.
// Ports: clk, rst_n (async active-low); ps2_clk, ps2_dat (raw pins);
//        left, right, backspace (pulses); symbol (ASCII pulse, 0 = none).
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_decoder #(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 25175
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps2_clk,
    input  logic                    ps2_dat,
    output logic                    left,
    output logic                    right,
    output logic                    backspace,
    output logic [SYMBOL_WIDTH-1:0] symbol
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_prev_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic          pfail_q, pfail_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    logic ext_q, ext_d;
    logic brk_q, brk_d;
    logic shift_q, shift_d;
    logic left_q, left_d;
    logic right_q, right_d;
    logic bs_q, bs_d;
    logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;

    logic fall;
    logic sdat;
    logic tmo_hit;
    logic abort;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign sdat    = dat_sync_q[1];
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
    assign abort   = (state_q != IDLE) && tmo_hit;

    // Synchronisers idle high so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:    if (!sdat) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        pfail_d      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d        = par_q;
`endif
        // Counter saturates at the limit instead of wrapping.
        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end
        if (fall && !abort) begin
            unique case (state_q)
                IDLE: bit_cnt_d = 3'd0;
                DATA: begin
                    shreg_d   = {sdat, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = sdat;
`endif
                end
                STOP: begin
`ifdef PS2_PARITY_CHECK_EN
                    // Odd parity: data bits plus parity bit XOR to 1.
                    if (^{shreg_q, par_q}) begin
                        byte_valid_d = sdat;
                    end else begin
                        pfail_d = 1'b1;
                    end
`else
                    byte_valid_d = sdat;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            pfail_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            pfail_q      <= pfail_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
`endif
        end
    end

    function automatic logic [6:0] ascii_of(
        input logic [7:0] code,
        input logic       shift
    );
        logic [6:0] a;
        a = 7'h00;
        case (code)
            8'h45: a = shift ? 7'h29 : 7'h30;
            8'h16: a = shift ? 7'h00 : 7'h31;
            8'h1E: a = shift ? 7'h00 : 7'h32;
            8'h26: a = shift ? 7'h00 : 7'h33;
            8'h25: a = shift ? 7'h00 : 7'h34;
            8'h2E: a = shift ? 7'h00 : 7'h35;
            8'h36: a = shift ? 7'h5E : 7'h36;
            8'h3D: a = shift ? 7'h00 : 7'h37;
            8'h3E: a = shift ? 7'h2A : 7'h38;
            8'h46: a = shift ? 7'h28 : 7'h39;
            8'h22: a = 7'h78;
            8'h4E: a = 7'h2D;
            8'h55: a = shift ? 7'h2B : 7'h00;
            8'h49: a = 7'h2E;
            8'h4A: a = 7'h2F;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        shift_d = shift_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        bs_d    = 1'b0;
        sym_d   = '0;
        if (pfail_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid_q) begin
            unique case (1'b1)
                (shreg_q == 8'hE0): ext_d = 1'b1;
                (shreg_q == 8'hF0): brk_d = 1'b1;
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (!ext_q && (shreg_q == 8'h12 ||
                                   shreg_q == 8'h59)) begin
                        shift_d = ~brk_q;
                    end else if (!brk_q) begin
                        if (ext_q) begin
                            left_d  = (shreg_q == 8'h6B);
                            right_d = (shreg_q == 8'h74);
                        end else begin
                            bs_d  = (shreg_q == 8'h66);
                            sym_d = SYMBOL_WIDTH'(ascii_of(shreg_q, shift_q));
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            shift_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            bs_q    <= 1'b0;
            sym_q   <= '0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            shift_q <= shift_d;
            left_q  <= left_d;
            right_q <= right_d;
            bs_q    <= bs_d;
            sym_q   <= sym_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign backspace = bs_q;
    assign symbol    = sym_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Randomized bench for ps2_keyboard_decoder with a keymap-table reference model.
// Checks event value and exact 2-cycle latency per frame, plus pulse totals.
module tb_ps2_keyboard_decoder;

    localparam int HALF = 8;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       left;
    logic       right;
    logic       backspace;
    logic [6:0] symbol;

    int n_tests = 0;
    int n_fail = 0;
    int seen_pulses = 0;
    int exp_pulses = 0;
    int multi_hot = 0;

    bit m_ext = 0;
    bit m_brk = 0;
    bit m_shift = 0;

    logic [6:0] plain_map [logic [7:0]];
    logic [6:0] shift_map [logic [7:0]];

    ps2_keyboard_decoder #(
        .SYMBOL_WIDTH(7),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .left(left),
        .right(right),
        .backspace(backspace),
        .symbol(symbol)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        int hot;
        if (rst_n) begin
            hot = int'(left) + int'(right) + int'(backspace) + int'(symbol != 7'd0);
            if (hot > 0) seen_pulses++;
            if (hot > 1) multi_hot++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] obs();
        return {left, right, backspace, symbol};
    endfunction

    task automatic fill_maps();
        logic [7:0] digs [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++) plain_map[digs[i]] = 7'h30 + 7'(i);
        plain_map[8'h22] = "x";
        plain_map[8'h4E] = "-";
        plain_map[8'h49] = ".";
        plain_map[8'h4A] = "/";
        shift_map[8'h36] = "^";
        shift_map[8'h3E] = "*";
        shift_map[8'h46] = "(";
        shift_map[8'h45] = ")";
        shift_map[8'h22] = "x";
        shift_map[8'h4E] = "-";
        shift_map[8'h55] = "+";
        shift_map[8'h49] = ".";
        shift_map[8'h4A] = "/";
    endtask

    // Expected event {left,right,backspace,symbol} for one received frame.
    task automatic model(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                         output logic [9:0] e);
        bit accept;
        e = '0;
        accept = stop_ok;
`ifdef PS2_PARITY_CHECK_EN
        if (!par_ok) begin
            m_ext = 0;
            m_brk = 0;
            accept = 0;
        end
`endif
        if (accept) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
                else if (!m_brk) begin
                    if (m_ext) begin
                        if (b == 8'h6B) e = 10'h200;
                        if (b == 8'h74) e = 10'h100;
                    end else if (b == 8'h66) e = 10'h080;
                    else if (m_shift && shift_map.exists(b)) e = {3'b000, shift_map[b]};
                    else if (!m_shift && plain_map.exists(b)) e = {3'b000, plain_map[b]};
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
        if (e != 0) exp_pulses++;
    endtask

    task automatic drive_bit(input logic v, input bit is_stop, input logic [9:0] e,
                             input string tag);
        ps2_dat = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (is_stop && i >= 3 && i <= 5)
                check($sformatf("%s@%0d", tag, i), 32'(obs()), (i == 4) ? 32'(e) : 32'd0);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                              input string tag);
        logic [9:0] e;
        logic       par;
        model(b, stop_ok, par_ok, e);
        par = par_ok ? ~^b : ^b;
        drive_bit(1'b0, 0, '0, tag);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 0, '0, tag);
        drive_bit(par, 0, '0, tag);
        drive_bit(stop_ok ? 1'b1 : 1'b0, 1, e, $sformatf("%s_%02h", tag, b));
        ps2_dat = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        send_frame(b, 1, 1, tag);
    endtask

    task automatic partial(input int nbits);
        drive_bit(1'b0, 0, '0, "part");
        for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)), 0, '0, "part");
        ps2_dat = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [24] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h6B, 8'h74,
                                  8'h66, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h22,
                                  8'h4E, 8'h55, 8'h49, 8'h4A, 8'hE0, 8'hF0};
        fill_maps();
        repeat (3) @(negedge clk);
        check("rst_out", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_out", 32'(obs()), 32'd0);

        // Shift held, then reset mid-frame must drop both partial frame and shift.
        send(8'h12, "shift");
        partial(4);
        @(negedge clk);
        rst_n = 1'b0;
        m_ext = 0;
        m_brk = 0;
        m_shift = 0;
        repeat (3) @(negedge clk);
        check("rst_mid", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h16, "after_rst");

        send(8'hE0, "l0");
        send(8'h6B, "left");
        send(8'hE0, "l1");
        send(8'hF0, "l2");
        send(8'h6B, "left_brk");

        send(8'h12, "s0");
        send(8'h3E, "star");
        send(8'hF0, "s1");
        send(8'h3E, "s2");
        send(8'hF0, "s3");
        send(8'h12, "s4");
        send(8'h3E, "eight");

        send_frame(8'h66, 0, 1, "bs_badstop");
        send(8'h66, "bs");

        partial(5);
        repeat (TMO + 50) @(negedge clk);
        send(8'h22, "x_after_tmo");

        send_frame(8'h4A, 1, 0, "slash_badpar");
        send(8'h4A, "slash");

        for (int n = 0; n < 120; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 6) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 23)];
            send_frame(b, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, "rnd");
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("pulse_total", 32'(seen_pulses), 32'(exp_pulses));
        check("one_hot", 32'(multi_hot), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_decoder.md
Name: ps2_keyboard_decoder

Overview:
- Receives PS/2 set-2 scancode frames from the keyboard pins and decodes them into editor events for the expression-entry logic.
- Events are cursor left, cursor right, backspace, and a 7-bit ASCII symbol.
- Sits between the board PS/2 pins and the logic block; runs on the 25.175 MHz pixel clock.
- Outputs are one-cycle pulses, so the logic block acts on each keypress exactly once.

Parameters:
- SYMBOL_WIDTH, 7, width of symbol output (ASCII code; 0 = no symbol).
- TIMEOUT_CYCLES, 25175, clk cycles (~1 ms) without a ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clk  input  1  system clock (25.175 MHz).
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin; asynchronous to clk.
- ps2_dat  input  1  raw PS/2 data pin; asynchronous to clk.
- left  output  1  one-cycle pulse: left-arrow make.
- right  output  1  one-cycle pulse: right-arrow make.
- backspace  output  1  one-cycle pulse: backspace make.
- symbol  output  SYMBOL_WIDTH  ASCII of a printable key make, valid for one cycle; 0 otherwise.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0, FSM in IDLE.
  - Prefix flags ext/brk and shift state cleared.
  - Synchronisers preset to 1 (bus idle high).
- Input sync: ps2_clk and ps2_dat each go through 2-FF synchronisers. A falling edge is sync_clk_prev=1 and sync_clk=0. Data is sampled in the same cycle the edge is detected.
- Frame FSM (advances only on falling edges):
  - IDLE: waits for start bit dat=0. Start bit 1 stays in IDLE.
  - DATA: shifts 8 bits LSB first, counted 0..7.
  - PARITY: samples the parity bit.
  - STOP: requires stop bit 1, otherwise the frame is discarded. Either way the FSM returns to IDLE.
  - A valid frame produces byte_valid for one cycle, one cycle after the stop edge.
- Timeout:
  - A counter is cleared on every falling edge and in IDLE; it increments otherwise.
  - Reaching TIMEOUT_CYCLES outside IDLE aborts the frame: return to IDLE with no byte.
  - The counter saturates and never wraps.
- Decode, on byte_valid:
  - E0: set ext. F0: set brk. Neither produces output.
  - Any other code: act on it, then clear ext and brk.
  - Shift: codes 12 and 59 with ext=0 set shift on make and clear it on break.
  - Break codes produce no outputs.
  - ext=1: 6B gives left, 74 gives right; all others are ignored.
  - ext=0:
    - 66 gives backspace.
    - Digit codes 45,16,1E,26,25,2E,36,3D,3E,46 give '0'..'9' unshifted. Shifted: 36 -> '^', 3E -> '*', 46 -> '(', 45 -> ')', other shifted digits -> no output.
    - 22 -> 'x'.
    - 4E -> '-'.
    - 55 -> '+' only when shifted.
    - 49 -> '.'.
    - 4A -> '/'.
    - Unmapped codes are ignored.
- Latency: outputs pulse exactly 2 clk cycles after the stop-bit falling edge is detected. At most one output is nonzero in any cycle.
- Edge cases:
  - Back-to-back frames are fully supported; byte handling is single-cycle, so nothing is dropped.
  - Reset mid-frame discards the partial frame and all prefix and shift state.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: odd parity over the 8 data bits plus the parity bit is checked in STOP; on failure the frame is discarded and ext/brk are cleared.
- Undefined: the parity bit is sampled but ignored; only the start and stop checks apply.

Test Plan:
- rst_n low mid-frame (after 4 data bits), release, then send 0x16 -> the partial frame is not decoded; symbol=0x31 ('1') for exactly one cycle, 2 cycles after the stop edge.
- Send E0 6B, then E0 F0 6B -> one left pulse; no pulse on the break.
- Send 12, 3E, F0 3E, F0 12, 3E -> symbol 0x2A ('*'), then 0x38 ('8'); no output for the break frames.
- Send 0x66 with the stop bit forced 0, then a good 0x66 -> exactly one backspace pulse.
- Stop ps2_clk after 5 data bits for TIMEOUT_CYCLES, then send 0x22 -> symbol 0x78 ('x'); no spurious output.
- With PS2_PARITY_CHECK_EN, send 0x4A with wrong parity -> no output; a correct 0x4A gives symbol 0x2F. Without the macro, both frames give 0x2F.
